// File: rtl/inst_fetch.sv
// Instruction fetch stage: SRAM-like fetch FSM feeding a small decode buffer.
// Define IFETCH_BUF2_EN for a two-entry buffer (default is one entry).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        de_ready,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        adelD
);

`ifdef IFETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StWaitAddr,
        StWaitData
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        cancel;
    logic        halt;
    logic [1:0]  count;

    logic [31:0] buf_pc    [DEPTH];
    logic [31:0] buf_instr [DEPTH];
    logic        buf_adel  [DEPTH];

    logic        pop;
    logic [1:0]  occ;
    logic        room;
    logic        can_fetch;
    logic        issue;
    logic        push_adel;
    logic        data_ret;
    logic        push_data;
    logic        push;
    logic [31:0] push_pc;
    logic [31:0] push_instr;

    always_comb begin
        pop        = 1'b0;
        occ        = count;
        room       = 1'b0;
        can_fetch  = 1'b0;
        issue      = 1'b0;
        push_adel  = 1'b0;
        data_ret   = 1'b0;
        push_data  = 1'b0;
        push       = 1'b0;
        push_pc    = req_pc;
        push_instr = inst_rdata;

        pop = (count != 2'd0) && de_ready && !redirect;
        // Occupancy after this cycle's pop; a new fetch reserves one slot.
        occ  = count - {1'b0, pop};
        room = int'(occ) < DEPTH;

        can_fetch = (state == StIdle) && !redirect && !halt && room;
        issue     = can_fetch && (pc[1:0] == 2'b00);
        push_adel = can_fetch && (pc[1:0] != 2'b00);

        data_ret  = inst_data_ok &&
                    ((state == StWaitData) || ((state == StWaitAddr) && inst_addr_ok));
        push_data = data_ret && !cancel && !redirect;

        push = push_data || push_adel;
        if (push_adel) begin
            push_pc    = pc;
            push_instr = 32'h0;
        end
    end

    // Fetch FSM, PC and request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= StIdle;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inst_req <= 1'b0;
            cancel   <= 1'b0;
            halt     <= 1'b0;
        end else begin
            if (redirect) begin
                halt <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (issue) begin
                        state    <= StWaitAddr;
                        inst_req <= 1'b1;
                        req_pc   <= pc;
                    end else if (push_adel) begin
                        halt <= 1'b1;
                    end
                end
                StWaitAddr: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        if (inst_data_ok) begin
                            state  <= StIdle;
                            cancel <= 1'b0;
                        end else begin
                            state  <= StWaitData;
                            cancel <= cancel | redirect;
                        end
                        // A cancelled request already has pc pointing at the redirect target.
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else if (!cancel) begin
                            pc <= pc + 32'd4;
                        end
                    end else begin
                        cancel <= cancel | redirect;
                        if (redirect) begin
                            pc <= redirect_pc;
                        end
                    end
                end
                StWaitData: begin
                    if (inst_data_ok) begin
                        state  <= StIdle;
                        cancel <= 1'b0;
                    end else begin
                        cancel <= cancel | redirect;
                    end
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                end
                default: begin
                    state    <= StIdle;
                    inst_req <= 1'b0;
                end
            endcase
        end
    end

    // Decode buffer: slot 0 is the head; pop shifts, push lands after the survivors.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= 32'h0;
                buf_instr[i] <= 32'h0;
                buf_adel[i]  <= 1'b0;
            end
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && (i < DEPTH - 1)) begin
                    buf_pc[i]    <= buf_pc[(i + 1) % DEPTH];
                    buf_instr[i] <= buf_instr[(i + 1) % DEPTH];
                    buf_adel[i]  <= buf_adel[(i + 1) % DEPTH];
                end
                if (push && (int'(occ) == i)) begin
                    buf_pc[i]    <= push_pc;
                    buf_instr[i] <= push_instr;
                    buf_adel[i]  <= push_adel;
                end
            end
        end
    end

    assign inst_addr = req_pc;
    assign validD    = (count != 2'd0);
    assign instrD    = buf_instr[0];
    assign pcD       = buf_pc[0];
    assign adelD     = buf_adel[0];

endmodule
